pc_update_unit: RTL and testbench

- Program-counter register stage that sits directly downstream of the PC-source multiplexer in the multicycle datapath.
- Commits the selected next PC under unconditional or branch-conditional write control.
- Runs the exception entry sequence: saves EPC, reads the one-byte handler address from the vector area of memory, and loads it into PC.
- Drives the exception-busy stall seen by the control unit.

---
 rtl/pc_update_unit.sv | 127 ++++++++++++
 tb/tb_pc_update_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_update_unit.sv
// Program-counter register stage: commits the muxed next PC (unconditional or
// branch-conditional) and runs the exception entry sequence through the vector area.
module pc_update_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] VEC_BASE = 32'd253,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_op,
  input  logic        zero,
  input  logic        gt,
  input  logic        exc_req,
  input  logic [1:0]  exc_code,
  input  logic [7:0]  mem_byte,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [31:0] vec_addr,
  output logic        vec_rd,
  output logic        exc_busy,
  output logic        pc_misaligned
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    LOAD  = 2'd3
  } state_e;

  localparam logic       HAS_WAIT = (MEM_LAT > 0) ? 1'b1 : 1'b0;
  localparam logic [2:0] LAT_LAST = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] pc_q;
  logic [31:0] epc_q;
  logic [31:0] vec_addr_q;
  logic        vec_rd_q;
  logic        busy_q;
  logic        mis_q;

  logic        cond_ok;
  logic        take_branch;
  logic [1:0]  cause;

  // Branch condition decode and exception cause normalisation
  always_comb begin
    cond_ok = 1'b0;
    case (branch_op)
      2'b00:   cond_ok = zero;
      2'b01:   cond_ok = ~zero;
      2'b10:   cond_ok = gt;
      2'b11:   cond_ok = ~gt;
      default: cond_ok = 1'b0;
    endcase
    take_branch = pc_write_cond & cond_ok;
    // Reserved cause shares the invalid-opcode vector.
    cause = (exc_code == 2'b11) ? 2'b00 : exc_code;
  end

  // PC / exception-entry FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      pc_q       <= RESET_PC;
      epc_q      <= 32'd0;
      vec_addr_q <= 32'd0;
      vec_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (exc_req) begin
            epc_q      <= pc_q - 32'd4;
            vec_addr_q <= VEC_BASE + {30'd0, cause};
            cnt_q      <= 3'd0;
            vec_rd_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= FETCH;
          end else if (pc_write || take_branch) begin
            pc_q  <= next_pc;
            mis_q <= (next_pc[1:0] != 2'b00);
          end else begin
            pc_q <= pc_q;
          end
        end
        FETCH: begin
          cnt_q   <= 3'd0;
          state_q <= HAS_WAIT ? WAIT : LOAD;
        end
        WAIT: begin
          if (cnt_q == LAT_LAST) begin
            state_q <= LOAD;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        LOAD: begin
          pc_q     <= {24'd0, mem_byte};
          mis_q    <= (mem_byte[1:0] != 2'b00);
          vec_rd_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          vec_rd_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign pc            = pc_q;
  assign epc           = epc_q;
  assign vec_addr      = vec_addr_q;
  assign vec_rd        = vec_rd_q;
  assign exc_busy      = busy_q;
  assign pc_misaligned = mis_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed, table-driven bench for pc_update_unit with hand-written exception sequences.
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_op;
  logic        zero;
  logic        gt;
  logic        exc_req;
  logic [1:0]  exc_code;
  logic [7:0]  mem_byte;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [31:0] vec_addr;
  logic        vec_rd;
  logic        exc_busy;
  logic        pc_misaligned;

  int n_cmp = 0;
  int n_fail = 0;

  pc_update_unit #(
    .RESET_PC(32'h0000_0000),
    .VEC_BASE(32'd253),
    .MEM_LAT (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .next_pc      (next_pc),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .branch_op    (branch_op),
    .zero         (zero),
    .gt           (gt),
    .exc_req      (exc_req),
    .exc_code     (exc_code),
    .mem_byte     (mem_byte),
    .pc           (pc),
    .epc          (epc),
    .vec_addr     (vec_addr),
    .vec_rd       (vec_rd),
    .exc_busy     (exc_busy),
    .pc_misaligned(pc_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pw;
    logic        pwc;
    logic [1:0]  op;
    logic        z;
    logic        g;
    logic [31:0] npc;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    next_pc = 32'd0; pc_write = 1'b0; pc_write_cond = 1'b0; branch_op = 2'b00;
    zero = 1'b0; gt = 1'b0; exc_req = 1'b0; exc_code = 2'b00;
  endtask

  task automatic write_pc(input logic [31:0] v);
    @(negedge clk);
    clear_inputs();
    pc_write = 1'b1; next_pc = v;
    @(posedge clk); #1;
    pc_write = 1'b0;
  endtask

  // Exception entry; optionally with a simultaneous pc_write, and with disturbances
  // (nested exc_req in FETCH, pc_write in WAIT) during the sequence.
  task automatic exc_seq(input string tag, input logic [1:0] code, input logic with_pw,
                         input logic disturb, input logic [7:0] hb,
                         input logic [31:0] exp_epc, input logic [31:0] exp_va);
    int   busy_n;
    int   hit_edge;
    logic saw_bad;
    @(negedge clk);
    clear_inputs();
    exc_req = 1'b1; exc_code = code; pc_write = with_pw; next_pc = 32'h200; mem_byte = hb;
    @(posedge clk); #1;
    exc_req = 1'b0; pc_write = 1'b0;
    check({tag, "_epc"}, epc, exp_epc);
    check({tag, "_vec_addr"}, vec_addr, exp_va);
    check({tag, "_vec_rd_fetch"}, {31'd0, vec_rd}, 32'd1);
    busy_n   = exc_busy ? 1 : 0;
    hit_edge = 0;
    saw_bad  = (pc == 32'h200);
    if (disturb) begin
      exc_req = 1'b1; exc_code = 2'b10;
    end
    for (int k = 2; k <= 8; k++) begin
      @(posedge clk); #1;
      exc_req = 1'b0; pc_write = 1'b0;
      if (disturb && k == 2) begin
        pc_write = 1'b1; next_pc = 32'h200;
      end
      if (exc_busy) busy_n++;
      if (pc == 32'h200) saw_bad = 1'b1;
      if (hit_edge == 0 && pc == {24'd0, hb}) hit_edge = k;
    end
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd3);
    check({tag, "_handler_edge"}, 32'(hit_edge), 32'd4);
    check({tag, "_no_0x200"}, {31'd0, saw_bad}, 32'd0);
    check({tag, "_pc_final"}, pc, {24'd0, hb});
    check({tag, "_epc_hold"}, epc, exp_epc);
    check({tag, "_vec_rd_done"}, {31'd0, vec_rd}, 32'd0);
    check({tag, "_mis"}, {31'd0, pc_misaligned}, {31'd0, (hb[1:0] != 2'b00)});
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0040, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_0040, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0100, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0100, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0300, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_0300, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_0300, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_0504, 32'h0000_0504, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h0000_0508, 32'h0000_0508, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0000_0600, 32'h0000_0508, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0042, 32'h0000_0042, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0088, 32'h0000_0088, 1'b0};

    clear_inputs();
    mem_byte = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_vec_addr", vec_addr, 32'h0);
    check("rst_flags", {28'd0, vec_rd, exc_busy, pc_misaligned, 1'b0}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      clear_inputs();
      pc_write = vecs[i].pw; pc_write_cond = vecs[i].pwc; branch_op = vecs[i].op;
      zero = vecs[i].z; gt = vecs[i].g; next_pc = vecs[i].npc;
      @(posedge clk); #1;
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_mis", i), {31'd0, pc_misaligned}, {31'd0, vecs[i].exp_mis});
    end

    // pc = 0x88, overflow cause -> vector 254, handler 0xA4
    exc_seq("exc1", 2'b01, 1'b0, 1'b0, 8'hA4, 32'h0000_0084, 32'd254);
    // pc = 0xA4, div-by-zero cause with simultaneous pc_write and in-sequence disturbances
    exc_seq("exc2", 2'b10, 1'b1, 1'b1, 8'h31, 32'h0000_00A0, 32'd255);
    // pc = 0, reserved cause maps to vector 253, epc wraps
    write_pc(32'h0000_0000);
    exc_seq("exc3", 2'b11, 1'b0, 1'b0, 8'h10, 32'hFFFF_FFFC, 32'd253);
    write_pc(32'h0000_0042);
    check("mis_after_42", {31'd0, pc_misaligned}, 32'd1);

    // Asynchronous reset while in WAIT
    @(negedge clk);
    clear_inputs();
    exc_req = 1'b1; exc_code = 2'b01; mem_byte = 8'h80;
    @(posedge clk); #1;
    exc_req = 1'b0;
    @(posedge clk); #3;
    check("wait_busy_before_rst", {31'd0, exc_busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_epc", epc, 32'h0);
    check("arst_vec_rd", {31'd0, vec_rd}, 32'd0);
    check("arst_busy", {31'd0, exc_busy}, 32'd0);
    check("arst_mis", {31'd0, pc_misaligned}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    write_pc(32'h0000_0044);
    check("post_rst_pc", pc, 32'h0000_0044);
    check("post_rst_busy", {31'd0, exc_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle_pc", pc, 32'h0000_0044);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
